// File: rtl/sram_req_sched_if.sv
// CPU-side SRAM-like ports and bridge-side read/write engine channels of the
// request scheduler. The scheduler is the slave; the CPU/bridge side is the master.
interface sram_req_sched_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    logic        rd_req;
    logic [3:0]  rd_id;
    logic [31:0] rd_addr;
    logic [2:0]  rd_size;
    logic        rd_ready;
    logic        rd_resp_valid;
    logic [3:0]  rd_resp_id;
    logic [31:0] rd_resp_data;

    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  wr_size;
    logic [3:0]  wr_strb;
    logic        wr_ready;
    logic        wr_done;

    logic        err;

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
        input  data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        output rd_req, rd_id, rd_addr, rd_size,
        input  rd_ready, rd_resp_valid, rd_resp_id, rd_resp_data,
        output wr_req, wr_addr, wr_data, wr_size, wr_strb,
        input  wr_ready, wr_done,
        output err
    );

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
        output data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        input  rd_req, rd_id, rd_addr, rd_size,
        output rd_ready, rd_resp_valid, rd_resp_id, rd_resp_data,
        input  wr_req, wr_addr, wr_data, wr_size, wr_strb,
        output wr_ready, wr_done,
        input  err
    );
endinterface

// File: rtl/sram_req_sched.sv
// Arbitrates inst/data SRAM requests onto the bridge read/write engines with
// starvation guard, per-source outstanding limits and data-port R/W ordering.
module sram_req_sched #(
    parameter int MAX_OUT    = 2,
    parameter int STARVE_LIM = 3
) (
    input  logic           clk,
    input  logic           resetn,
    sram_req_sched_if.slave bus
);
    localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

    typedef logic [2:0]    cnt_t;
    typedef logic [SW-1:0] stv_t;

    localparam cnt_t MAX_C = cnt_t'(MAX_OUT);
    localparam stv_t LIM_C = stv_t'(STARVE_LIM);

    cnt_t inst_cnt, data_cnt, wr_cnt;
    stv_t starve;
    logic err_q;

    logic inst_ok, drd_ok, dwr_ok, data_elig;
    logic gnt_inst, gnt_data;
    logic inst_acc, drd_acc, dwr_acc;
    logic inst_dec, data_dec, wr_dec, bad_id, err_set;

    // Saturating-at-zero up/down counter; a stray decrement at zero is an error, not a wrap.
    function automatic cnt_t cnt_next(cnt_t c, logic inc, logic dec);
        if (inc && !dec)                return c + 3'd1;
        if (dec && !inc && c != 3'd0)   return c - 3'd1;
        return c;
    endfunction

    always_comb begin
        inst_ok   = bus.inst_sram_req && (inst_cnt < MAX_C);
        drd_ok    = bus.data_sram_req && !bus.data_sram_wr && (data_cnt < MAX_C) && (wr_cnt == 3'd0);
        dwr_ok    = bus.data_sram_req &&  bus.data_sram_wr && (wr_cnt < MAX_C) && (data_cnt == 3'd0);
        data_elig = drd_ok || dwr_ok;
        gnt_inst  = inst_ok && (!data_elig || starve == LIM_C);
        gnt_data  = data_elig && !gnt_inst;

        inst_acc  = gnt_inst && bus.rd_ready;
        drd_acc   = gnt_data && !bus.data_sram_wr && bus.rd_ready;
        dwr_acc   = gnt_data &&  bus.data_sram_wr && bus.wr_ready;

        inst_dec  = bus.rd_resp_valid && (bus.rd_resp_id == 4'd0);
        data_dec  = bus.rd_resp_valid && (bus.rd_resp_id == 4'd1);
        wr_dec    = bus.wr_done;
        bad_id    = bus.rd_resp_valid && (bus.rd_resp_id > 4'd1);
        err_set   = (inst_dec && inst_cnt == 3'd0) || (data_dec && data_cnt == 3'd0) ||
                    (wr_dec && wr_cnt == 3'd0) || bad_id || (data_dec && wr_dec);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_cnt <= '0;
            data_cnt <= '0;
            wr_cnt   <= '0;
            starve   <= '0;
            err_q    <= 1'b0;
        end else begin
            inst_cnt <= cnt_next(inst_cnt, inst_acc, inst_dec);
            data_cnt <= cnt_next(data_cnt, drd_acc, data_dec);
            wr_cnt   <= cnt_next(wr_cnt, dwr_acc, wr_dec);
            if (!bus.inst_sram_req || inst_acc)
                starve <= '0;
            else if ((drd_acc || dwr_acc) && starve != LIM_C)
                starve <= starve + stv_t'(1);
            if (err_set)
                err_q <= 1'b1;
        end
    end

    // Every output is forced low while reset is held, including the pass-through response path.
    always_comb begin
        bus.inst_sram_addr_ok = 1'b0;
        bus.inst_sram_data_ok = 1'b0;
        bus.inst_sram_rdata   = '0;
        bus.data_sram_addr_ok = 1'b0;
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = '0;
        bus.rd_req            = 1'b0;
        bus.rd_id             = '0;
        bus.rd_addr           = '0;
        bus.rd_size           = '0;
        bus.wr_req            = 1'b0;
        bus.wr_addr           = '0;
        bus.wr_data           = '0;
        bus.wr_size           = '0;
        bus.wr_strb           = '0;
        bus.err               = 1'b0;
        if (resetn) begin
            bus.err = err_q;
            if (gnt_inst) begin
                bus.rd_req  = 1'b1;
                bus.rd_id   = 4'd0;
                bus.rd_addr = bus.inst_sram_addr;
                bus.rd_size = {1'b0, bus.inst_sram_size};
            end else if (gnt_data && !bus.data_sram_wr) begin
                bus.rd_req  = 1'b1;
                bus.rd_id   = 4'd1;
                bus.rd_addr = bus.data_sram_addr;
                bus.rd_size = {1'b0, bus.data_sram_size};
            end else if (gnt_data) begin
                bus.wr_req  = 1'b1;
                bus.wr_addr = bus.data_sram_addr;
                bus.wr_data = bus.data_sram_wdata;
                bus.wr_size = {1'b0, bus.data_sram_size};
                bus.wr_strb = bus.data_sram_wstrb;
            end
            bus.inst_sram_addr_ok = inst_acc;
            bus.data_sram_addr_ok = drd_acc || dwr_acc;
            bus.inst_sram_data_ok = inst_dec;
            bus.inst_sram_rdata   = inst_dec ? bus.rd_resp_data : 32'h0;
            bus.data_sram_data_ok = data_dec || wr_dec;
            bus.data_sram_rdata   = data_dec ? bus.rd_resp_data : 32'h0;
        end
    end
endmodule

// File: tb/tb_sram_req_sched.sv
// Directed bench for sram_req_sched: inputs change 1ns after posedge, outputs
// are sampled 1ns later, well clear of the active edge.
module tb_sram_req_sched;
    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    sram_req_sched_if bus();

    sram_req_sched #(.MAX_OUT(2), .STARVE_LIM(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.inst_sram_req   = 1'b0;
        bus.inst_sram_wr    = 1'b0;
        bus.inst_sram_size  = 2'd0;
        bus.inst_sram_addr  = 32'h0;
        bus.data_sram_req   = 1'b0;
        bus.data_sram_wr    = 1'b0;
        bus.data_sram_size  = 2'd0;
        bus.data_sram_wstrb = 4'h0;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;
        bus.rd_ready        = 1'b0;
        bus.rd_resp_valid   = 1'b0;
        bus.rd_resp_id      = 4'd0;
        bus.rd_resp_data    = 32'h0;
        bus.wr_ready        = 1'b0;
        bus.wr_done         = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clear_inputs();
        bus.inst_sram_req = 1'b1;
        bus.rd_ready      = 1'b1;
        #2;
        checks++; if (bus.rd_req !== 1'b0) begin failures++; $display("FAIL rst_rd_req got=%0h exp=0", bus.rd_req); end
        checks++; if (bus.inst_sram_addr_ok !== 1'b0) begin failures++; $display("FAIL rst_addr_ok got=%0h exp=0", bus.inst_sram_addr_ok); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0h exp=0", bus.err); end
        step(); step();
        clear_inputs();
        resetn = 1'b1;
        #1;
        checks++; if (dut.inst_cnt !== 3'd0 || dut.wr_cnt !== 3'd0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", dut.inst_cnt, dut.wr_cnt); end
    endtask

    task automatic test_inst_read();
        step();
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'hBFC00000;
        bus.inst_sram_size = 2'd2;
        bus.rd_ready       = 1'b1;
        #1;
        checks++; if (bus.inst_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL t1_addr_ok got=%0h exp=1", bus.inst_sram_addr_ok); end
        checks++; if ({bus.rd_req, bus.rd_id, bus.rd_addr, bus.rd_size} !== {1'b1, 4'd0, 32'hBFC00000, 3'b010})
            begin failures++; $display("FAIL t1_rd_bus got=%0h/%0h/%0h/%0h exp=1/0/bfc00000/2", bus.rd_req, bus.rd_id, bus.rd_addr, bus.rd_size); end
        step();
        clear_inputs();
        #1;
        checks++; if (bus.inst_sram_data_ok !== 1'b0) begin failures++; $display("FAIL t1_early_data_ok got=%0h exp=0", bus.inst_sram_data_ok); end
        step();
        bus.rd_resp_valid = 1'b1;
        bus.rd_resp_id    = 4'd0;
        bus.rd_resp_data  = 32'h3C1D0001;
        #1;
        checks++; if (bus.inst_sram_data_ok !== 1'b1 || bus.inst_sram_rdata !== 32'h3C1D0001)
            begin failures++; $display("FAIL t1_data_ok got=%0h/%0h exp=1/3c1d0001", bus.inst_sram_data_ok, bus.inst_sram_rdata); end
        checks++; if (bus.data_sram_data_ok !== 1'b0) begin failures++; $display("FAIL t1_data_port got=%0h exp=0", bus.data_sram_data_ok); end
        step();
        clear_inputs();
        #1;
        checks++; if (dut.inst_cnt !== 3'd0 || bus.err !== 1'b0) begin failures++; $display("FAIL t1_cnt_err got=%0d/%0h exp=0/0", dut.inst_cnt, bus.err); end
        checks++; if (bus.inst_sram_rdata !== 32'h0) begin failures++; $display("FAIL t1_rdata_idle got=%0h exp=0", bus.inst_sram_rdata); end
    endtask

    task automatic test_ready_hold();
        step();
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'h100;
        #1;
        checks++; if (bus.rd_req !== 1'b1 || bus.rd_id !== 4'd0 || bus.inst_sram_addr_ok !== 1'b0)
            begin failures++; $display("FAIL hold_inst got=%0h/%0h/%0h exp=1/0/0", bus.rd_req, bus.rd_id, bus.inst_sram_addr_ok); end
        step();
        bus.data_sram_req  = 1'b1;
        bus.data_sram_addr = 32'h200;
        #1;
        checks++; if (bus.rd_id !== 4'd1 || bus.rd_addr !== 32'h200 || bus.data_sram_addr_ok !== 1'b0)
            begin failures++; $display("FAIL hold_switch got=%0h/%0h/%0h exp=1/200/0", bus.rd_id, bus.rd_addr, bus.data_sram_addr_ok); end
        step();
        bus.rd_ready = 1'b1;
        #1;
        checks++; if (bus.data_sram_addr_ok !== 1'b1 || bus.inst_sram_addr_ok !== 1'b0)
            begin failures++; $display("FAIL hold_data_acc got=%0h/%0h exp=1/0", bus.data_sram_addr_ok, bus.inst_sram_addr_ok); end
        step();
        bus.data_sram_req = 1'b0;
        #1;
        checks++; if (bus.inst_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL hold_inst_acc got=%0h exp=1", bus.inst_sram_addr_ok); end
        step();
        clear_inputs();
        bus.rd_resp_valid = 1'b1;
        bus.rd_resp_id    = 4'd1;
        bus.rd_resp_data  = 32'h11112222;
        #1;
        checks++; if (bus.data_sram_data_ok !== 1'b1 || bus.data_sram_rdata !== 32'h11112222)
            begin failures++; $display("FAIL hold_resp1 got=%0h/%0h exp=1/11112222", bus.data_sram_data_ok, bus.data_sram_rdata); end
        step();
        bus.rd_resp_id = 4'd0;
        step();
        clear_inputs();
        #1;
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL hold_err got=%0h exp=0", bus.err); end
    endtask

    task automatic test_starve();
        logic [3:0] exp_id [8];
        logic       pend;
        logic [3:0] pid;
        exp_id = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd1, 4'd1, 4'd1, 4'd0};
        pend = 1'b0;
        pid  = 4'd0;
        step();
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'h400;
        bus.data_sram_req  = 1'b1;
        bus.data_sram_addr = 32'h800;
        bus.rd_ready       = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.rd_resp_valid = pend;
            bus.rd_resp_id    = pid;
            #1;
            checks++; if (bus.rd_req !== 1'b1 || bus.rd_id !== exp_id[i])
                begin failures++; $display("FAIL t2_grant[%0d] got=%0h/%0h exp=1/%0h", i, bus.rd_req, bus.rd_id, exp_id[i]); end
            pend = 1'b1;
            pid  = exp_id[i];
            step();
        end
        clear_inputs();
        bus.rd_resp_valid = 1'b1;
        bus.rd_resp_id    = pid;
        step();
        clear_inputs();
        #1;
        checks++; if (dut.inst_cnt !== 3'd0 || dut.data_cnt !== 3'd0 || bus.err !== 1'b0)
            begin failures++; $display("FAIL t2_drain got=%0d/%0d/%0h exp=0/0/0", dut.inst_cnt, dut.data_cnt, bus.err); end
    endtask

    task automatic test_raw_hazard();
        step();
        bus.data_sram_req   = 1'b1;
        bus.data_sram_wr    = 1'b1;
        bus.data_sram_addr  = 32'h1000;
        bus.data_sram_wdata = 32'hDEADBEEF;
        bus.data_sram_wstrb = 4'hF;
        bus.data_sram_size  = 2'd2;
        bus.wr_ready        = 1'b1;
        bus.rd_ready        = 1'b1;
        #1;
        checks++; if ({bus.wr_req, bus.wr_addr, bus.wr_data, bus.wr_strb, bus.wr_size} !== {1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 3'b010})
            begin failures++; $display("FAIL t3_wr_bus got=%0h/%0h/%0h/%0h/%0h exp=1/1000/deadbeef/f/2", bus.wr_req, bus.wr_addr, bus.wr_data, bus.wr_strb, bus.wr_size); end
        checks++; if (bus.data_sram_addr_ok !== 1'b1 || bus.rd_req !== 1'b0)
            begin failures++; $display("FAIL t3_wr_acc got=%0h/%0h exp=1/0", bus.data_sram_addr_ok, bus.rd_req); end
        step();
        bus.data_sram_wr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (bus.rd_req !== 1'b0 || bus.data_sram_addr_ok !== 1'b0)
                begin failures++; $display("FAIL t3_rd_blocked[%0d] got=%0h/%0h exp=0/0", i, bus.rd_req, bus.data_sram_addr_ok); end
            step();
        end
        bus.wr_done = 1'b1;
        #1;
        checks++; if (bus.data_sram_data_ok !== 1'b1 || bus.data_sram_rdata !== 32'h0 || bus.rd_req !== 1'b0)
            begin failures++; $display("FAIL t3_wr_done got=%0h/%0h/%0h exp=1/0/0", bus.data_sram_data_ok, bus.data_sram_rdata, bus.rd_req); end
        step();
        bus.wr_done = 1'b0;
        #1;
        checks++; if ({bus.rd_req, bus.rd_id, bus.rd_addr, bus.data_sram_addr_ok} !== {1'b1, 4'd1, 32'h1000, 1'b1})
            begin failures++; $display("FAIL t3_rd_issue got=%0h/%0h/%0h/%0h exp=1/1/1000/1", bus.rd_req, bus.rd_id, bus.rd_addr, bus.data_sram_addr_ok); end
        step();
        clear_inputs();
        bus.rd_resp_valid = 1'b1;
        bus.rd_resp_id    = 4'd1;
        bus.rd_resp_data  = 32'hDEADBEEF;
        #1;
        checks++; if (bus.data_sram_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL t3_rdata got=%0h exp=deadbeef", bus.data_sram_rdata); end
        step();
        clear_inputs();
    endtask

    task automatic test_max_out();
        logic [3:0] exp_ok;
        exp_ok = 4'b0011;
        step();
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'h2000;
        bus.rd_ready       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.inst_sram_addr_ok !== exp_ok[i])
                begin failures++; $display("FAIL t4_addr_ok[%0d] got=%0h exp=%0h", i, bus.inst_sram_addr_ok, exp_ok[i]); end
            step();
        end
        bus.rd_resp_valid = 1'b1;
        bus.rd_resp_id    = 4'd0;
        #1;
        checks++; if (bus.inst_sram_addr_ok !== 1'b0 || bus.rd_req !== 1'b0)
            begin failures++; $display("FAIL t4_resp_cycle got=%0h/%0h exp=0/0", bus.inst_sram_addr_ok, bus.rd_req); end
        step();
        bus.rd_resp_valid = 1'b0;
        #1;
        checks++; if (bus.inst_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL t4_third_acc got=%0h exp=1", bus.inst_sram_addr_ok); end
        step();
        clear_inputs();
        bus.rd_resp_valid = 1'b1;
        bus.rd_resp_id    = 4'd0;
        step(); step();
        clear_inputs();
        #1;
        checks++; if (dut.inst_cnt !== 3'd0 || bus.err !== 1'b0)
            begin failures++; $display("FAIL t4_drain got=%0d/%0h exp=0/0", dut.inst_cnt, bus.err); end
    endtask

    task automatic test_war_order();
        step();
        bus.data_sram_req  = 1'b1;
        bus.data_sram_addr = 32'h3000;
        bus.rd_ready       = 1'b1;
        bus.wr_ready       = 1'b1;
        step();
        bus.data_sram_wr    = 1'b1;
        bus.data_sram_wdata = 32'hA5A5A5A5;
        bus.data_sram_wstrb = 4'h3;
        #1;
        checks++; if (bus.wr_req !== 1'b0 || bus.data_sram_addr_ok !== 1'b0)
            begin failures++; $display("FAIL t5_wr_blocked got=%0h/%0h exp=0/0", bus.wr_req, bus.data_sram_addr_ok); end
        step();
        bus.rd_resp_valid = 1'b1;
        bus.rd_resp_id    = 4'd1;
        #1;
        checks++; if (bus.wr_req !== 1'b0) begin failures++; $display("FAIL t5_wr_resp_cycle got=%0h exp=0", bus.wr_req); end
        step();
        bus.rd_resp_valid = 1'b0;
        #1;
        checks++; if (bus.wr_req !== 1'b1 || bus.wr_strb !== 4'h3 || bus.data_sram_addr_ok !== 1'b1)
            begin failures++; $display("FAIL t5_wr_issue got=%0h/%0h/%0h exp=1/3/1", bus.wr_req, bus.wr_strb, bus.data_sram_addr_ok); end
        step();
        clear_inputs();
        bus.wr_done = 1'b1;
        step();
        clear_inputs();
        #1;
        checks++; if (dut.wr_cnt !== 3'd0 || bus.err !== 1'b0)
            begin failures++; $display("FAIL t5_drain got=%0d/%0h exp=0/0", dut.wr_cnt, bus.err); end
    endtask

    task automatic test_errors();
        step();
        bus.rd_resp_valid = 1'b1;
        bus.rd_resp_id    = 4'd0;
        #1;
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL t6_err_early got=%0h exp=0", bus.err); end
        step();
        clear_inputs();
        #1;
        checks++; if (bus.err !== 1'b1 || dut.inst_cnt !== 3'd0)
            begin failures++; $display("FAIL t6_err_underflow got=%0h/%0d exp=1/0", bus.err, dut.inst_cnt); end
        step(); step();
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL t6_err_sticky got=%0h exp=1", bus.err); end
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        #1;
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL t6_err_clear got=%0h exp=0", bus.err); end
        step();
        bus.rd_resp_valid = 1'b1;
        bus.rd_resp_id    = 4'd5;
        #1;
        checks++; if (bus.inst_sram_data_ok !== 1'b0 || bus.data_sram_data_ok !== 1'b0)
            begin failures++; $display("FAIL t6_bad_id_route got=%0h/%0h exp=0/0", bus.inst_sram_data_ok, bus.data_sram_data_ok); end
        step();
        clear_inputs();
        #1;
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL t6_bad_id_err got=%0h exp=1", bus.err); end
        bus.inst_sram_req = 1'b1;
        bus.rd_ready      = 1'b1;
        bus.rd_resp_valid = 1'b1;
        bus.rd_resp_id    = 4'd0;
        bus.rd_resp_data  = 32'h12345678;
        #2;
        resetn = 1'b0;
        #1;
        checks++; if ({bus.rd_req, bus.inst_sram_addr_ok, bus.inst_sram_data_ok, bus.inst_sram_rdata, bus.err} !== 36'h0)
            begin failures++; $display("FAIL t6_reset_mid got=%0h/%0h/%0h/%0h/%0h exp=0", bus.rd_req, bus.inst_sram_addr_ok, bus.inst_sram_data_ok, bus.inst_sram_rdata, bus.err); end
        step();
        clear_inputs();
        resetn = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        clear_inputs();
        test_reset();
        test_inst_read();
        test_ready_hold();
        test_starve();
        test_raw_hazard();
        test_max_out();
        test_war_order();
        test_errors();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
